// File: rtl/dram_bank_model.sv
// Single-bank DRAM timing model with a closed-page policy.
// Each request runs ACT -> CAS -> BURST -> (WR) -> PRE; out-of-range rows get a one-cycle error.
module dram_bank_model #(
  parameter int TRCD_CYCLES = 8,
  parameter int TCL_CYCLES  = 8,
  parameter int TWR_CYCLES  = 7,
  parameter int TRP_CYCLES  = 8,
  parameter int BURST_LEN   = 1,
  parameter int NUM_ROWS    = 100,
  parameter int ADDRESS_LEN = 10,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDRESS_LEN-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   resp_valid,
  output logic                   resp_write,
  output logic                   resp_err,
  output logic [DATA_WIDTH-1:0]  resp_rdata
);

  localparam int M01   = (TRCD_CYCLES > TCL_CYCLES) ? TRCD_CYCLES : TCL_CYCLES;
  localparam int M23   = (TWR_CYCLES > TRP_CYCLES) ? TWR_CYCLES : TRP_CYCLES;
  localparam int M03   = (M01 > M23) ? M01 : M23;
  localparam int MAXC  = (M03 > BURST_LEN) ? M03 : BURST_LEN;
  localparam int CW    = $clog2(MAXC + 1);
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  localparam logic [CW-1:0] TRCD_M1  = CW'(TRCD_CYCLES - 1);
  localparam logic [CW-1:0] TCL_M1   = CW'(TCL_CYCLES - 1);
  localparam logic [CW-1:0] TWR_M1   = CW'(TWR_CYCLES - 1);
  localparam logic [CW-1:0] TRP_M1   = CW'(TRP_CYCLES - 1);
  localparam logic [CW-1:0] BURST_M1 = CW'(BURST_LEN - 1);
  localparam logic [ADDRESS_LEN:0] ROWS_X = (ADDRESS_LEN + 1)'(NUM_ROWS);

  if (TRCD_CYCLES < 1 || TCL_CYCLES < 1 || TWR_CYCLES < 1 ||
      TRP_CYCLES < 1 || BURST_LEN < 1) begin : g_bad_cycles
    $error("dram_bank_model: all cycle parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_CAS, S_BURST, S_WR, S_PRE, S_ERR
  } state_t;

  typedef struct packed {
    logic                   write;
    logic [ADDRESS_LEN-1:0] addr;
    logic [DATA_WIDTH-1:0]  wdata;
  } req_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  req_t                   req_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [DATA_WIDTH-1:0]  mem [NUM_ROWS];
  logic [ROW_W-1:0]       row;
  logic                   accept, addr_oob, last_beat, rd_fire, wr_fire;

  assign row       = req_q.addr[ROW_W-1:0];
  assign accept    = req_valid & req_ready;
  assign addr_oob  = {1'b0, req_addr} >= ROWS_X;
  assign last_beat = (state == S_BURST) && (cnt == '0);
  assign rd_fire   = last_beat & ~req_q.write;
  assign wr_fire   = last_beat &  req_q.write;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == S_IDLE) begin
      if (req_valid) begin
        state_n = addr_oob ? S_ERR : S_ACT;
        cnt_n   = addr_oob ? '0 : TRCD_M1;
      end
    end else if (cnt != '0) begin
      cnt_n = cnt - CW'(1);
    end else begin
      // counter expired: enter the next phase with its own length
      case (state)
        S_ACT:   begin state_n = S_CAS;   cnt_n = TCL_M1;   end
        S_CAS:   begin state_n = S_BURST; cnt_n = BURST_M1; end
        S_BURST: begin
          state_n = req_q.write ? S_WR : S_PRE;
          cnt_n   = req_q.write ? TWR_M1 : TRP_M1;
        end
        S_WR:    begin state_n = S_PRE;   cnt_n = TRP_M1;   end
        default: begin state_n = S_IDLE;  cnt_n = '0;       end
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = last_beat || (state == S_ERR);
    resp_err   = (state == S_ERR);
    resp_write = resp_valid & req_q.write;
    resp_rdata = rdata_q;
    if (state == S_ERR)  resp_rdata = '0;
    else if (rd_fire)    resp_rdata = mem[row];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept)             req_q   <= '{req_write, req_addr, req_wdata};
      if (state == S_ERR)     rdata_q <= '0;
      else if (rd_fire)       rdata_q <= mem[row];
    end
  end

  // Array contents survive reset; a write only lands on its final burst edge.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[row] <= req_q.wdata;
  end

endmodule

// File: doc/dram_bank_model.md
# dram_bank_model

Cycle-accurate single-bank DRAM model with a closed-page policy, enforcing DDR3-1066 command spacing (tRCD, tCL, burst, tWR, tRP) on every access. It sits directly downstream of the PIM/CPU request issuer and consumes one row-granular read or write request at a time. It returns read data or write completion after the modelled latency. Latency and geometry parameters default to the shared `types` package values.

## Interface
- `TRCD_CYCLES`, default 8: cycles from ACTIVATE to column command.
- `TCL_CYCLES`, default 8: cycles from column command to first burst beat.
- `TWR_CYCLES`, default 7: write recovery cycles before precharge.
- `TRP_CYCLES`, default 8: precharge cycles.
- `BURST_LEN`, default 1: burst beats; the full row transfers on the last beat.
- `NUM_ROWS`, default 100: rows in the bank.
- `ADDRESS_LEN`, default 10: address width.
- `DATA_WIDTH`, default 64: row/access width. PIM emulation sets 65536.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: block is accepting a request.
- `req_write`, input, 1: 1 = write, 0 = read.
- `req_addr`, input, ADDRESS_LEN: row address.
- `req_wdata`, input, DATA_WIDTH: write data.
- `resp_valid`, output, 1: one-cycle completion pulse.
- `resp_write`, output, 1: completed request was a write.
- `resp_err`, output, 1: address was out of range.
- `resp_rdata`, output, DATA_WIDTH: read data, valid with `resp_valid` on reads.

## Operation
- Storage is NUM_ROWS × DATA_WIDTH. Reset does not clear it.
- A request, with its addr, write flag and wdata, is latched on any edge where `req_valid & req_ready`.
- **States and transitions:**
  - IDLE: `req_ready` = 1. On accept, go to ACT, or to ERR if `req_addr >= NUM_ROWS`.
  - ACT: stay TRCD_CYCLES cycles, then go to CAS.
  - CAS: stay TCL_CYCLES cycles, then go to BURST.
  - BURST: stay BURST_LEN cycles.
    - On the last cycle: `resp_valid` = 1.
    - Read: `resp_rdata` = `mem[addr]`.
    - Write: `mem[addr]` ← wdata on that cycle's closing edge.
    - Next state is WR for a write, PRE for a read.
  - WR: stay TWR_CYCLES cycles, then go to PRE.
  - PRE: stay TRP_CYCLES cycles, then go to IDLE.
  - ERR: one cycle with `resp_valid` = `resp_err` = 1 and `resp_rdata` = 0. No array access. Then go to IDLE.
- A single down-counter is loaded on each state entry with that state's cycle count minus 1. The state exits when the counter is 0.
  - Counter width is `$clog2(max(TRCD_CYCLES, TCL_CYCLES, TWR_CYCLES, TRP_CYCLES, BURST_LEN)+1)`.
  - All cycle parameters must be ≥ 1. Elaboration-time assertion.
- No response backpressure. The consumer must take `resp_valid` in its cycle.
- `resp_write` mirrors the latched write flag during `resp_valid`, else 0.
- `req_valid` while `req_ready` = 0 is ignored, not queued. The requester must hold the request.

## Timing
- **Reset values:** `req_ready` = 1 (state IDLE, counter 0); `resp_valid`, `resp_write`, `resp_err` = 0; `resp_rdata` = 0.
- **Asynchronous reset:** assertion at any point, including mid-access, returns the block to IDLE immediately.
  - An in-flight write whose BURST edge has not occurred is dropped; memory is unchanged.
- Acceptance edge is E0. `req_ready` falls in cycle 1.
- **Read (defaults):**
  - ACT cycles 1–8, CAS 9–16, BURST 17.
  - `resp_valid` in cycle TRCD+TCL+BURST_LEN = 17.
  - PRE 18–25; `req_ready` = 1 in cycle 26.
  - Occupancy is 1+TRCD+TCL+BURST_LEN+TRP = 26 cycles.
- **Write (defaults):**
  - `resp_valid` in cycle 17; data committed at E17.
  - WR 18–24, PRE 25–32; `req_ready` in cycle 33.
- **Error:** `resp_valid`/`resp_err` in cycle 1; `req_ready` in cycle 2.
- **Back-to-back:** a request held across IDLE is accepted on the first IDLE edge, with no bubble beyond the stated occupancy.
- `resp_rdata` holds its last read value after `resp_valid` drops. It returns to 0 only on reset or an error response.

## Test plan
- **Read latency:** reset, write 0xA5A5 to row 3, then read row 3.
  - `resp_valid` 17 cycles after read acceptance.
  - `resp_rdata` = 0xA5A5, `resp_write` = 0, `resp_err` = 0.
- **Write occupancy:** write row 0 with `req_valid` held for a second write to row 1.
  - First `resp_valid` (`resp_write` = 1) at cycle 17.
  - Second request accepted exactly at E33.
  - Reading both rows returns the written data.
- **Out of range:** read `addr` = 100.
  - `resp_valid` and `resp_err` = 1 in cycle 1; `resp_rdata` = 0.
  - `req_ready` back in cycle 2; memory unchanged.
- **Ignored while busy:** pulse `req_valid` for one cycle during ACT of a read.
  - No extra response.
  - `req_ready` rises only at cycle 26.
- **Reset mid-write:** assert `rst_n` = 0 in cycle 10 of a write to row 5 (previous contents 0x1).
  - All outputs reach reset values without waiting for a clock edge.
  - A subsequent read of row 5 returns 0x1.
- **Parameter sweep:** TRCD = TCL = TRP = TWR = 1, BURST_LEN = 2.
  - Read `resp_valid` at cycle 4; `req_ready` at cycle 6.
  - Write `req_ready` at cycle 7.
